light_timer: RTL and testbench

- Seconds-resolution countdown timer that serves the traffic-light controller FSM.
- Accepts a start pulse and a length in seconds from the controller.
- Returns a level-held done flag and a flicker signal that blinks during the final seconds of an interval.
- Contains a clock prescaler, so the controller runs at the system clock while the timer counts wall-clock seconds.

---
 rtl/light_timer.sv | 66 ++++++
 tb/tb_light_timer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/light_timer.sv
// light_timer: seconds-resolution countdown timer for the traffic-light controller
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   t_start     one-cycle load/start request; t_length is sampled with it
//   t_length    interval length in seconds
//   t_done      high from expiry until the next t_start
//   t_flicker   blinks in the first half of each of the final FLICKER_SECS seconds
//   t_busy      high while counting
//   t_remaining whole seconds left in the current interval
//   sec_tick    one-cycle pulse after each second boundary, including the last
module light_timer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int FLICKER_SECS  = 5,
   parameter int LEN_W         = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t_start,
   input  logic [LEN_W-1:0] t_length,
   output logic             t_done,
   output logic             t_flicker,
   output logic             t_busy,
   output logic [LEN_W-1:0] t_remaining,
   output logic             sec_tick
);
   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]       state;
   logic [LEN_W-1:0] remaining;
   logic [PW-1:0]    presc;
   logic             tick;
   logic             wrap;
   assign wrap = (state == RUN) && (presc == LAST);
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         presc     <= '0;
         tick      <= 1'b0;
      end else if (t_start) begin
         // a start always wins, even over the final wrap of a running interval
         state     <= (t_length != '0) ? RUN : DONE;
         remaining <= t_length;
         presc     <= '0;
         tick      <= 1'b0;
      end else begin
         tick <= wrap;
         if (state == RUN) begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) begin
               remaining <= remaining - 1'b1;
               if (remaining == LEN_W'(1)) state <= DONE;
            end
         end
      end
   end
   assign t_busy      = (state == RUN);
   assign t_done      = (state == DONE);
   assign t_remaining = remaining;
   assign sec_tick    = tick;
   assign t_flicker   = t_busy && (32'(remaining) <= FLICKER_SECS) && (presc < HALF);
endmodule

// File: tb/tb_light_timer.sv
// tb_light_timer: directed self-checking bench for light_timer (4 ticks/s, 2 flicker secs)
module tb_light_timer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       t_start = 1'b0;
   logic [4:0] t_length = '0;
   logic       t_done, t_flicker, t_busy, sec_tick;
   logic [4:0] t_remaining;
   int errors = 0;
   int checks = 0;

   light_timer #(.TICKS_PER_SEC(4), .FLICKER_SECS(2), .LEN_W(5)) dut (
      .clk(clk), .reset(reset), .t_start(t_start), .t_length(t_length),
      .t_done(t_done), .t_flicker(t_flicker), .t_busy(t_busy),
      .t_remaining(t_remaining), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic d, input logic f, input logic b,
                          input logic [4:0] r, input logic s);
      chk({tag, ".done"}, 32'(t_done), 32'(d));
      chk({tag, ".flicker"}, 32'(t_flicker), 32'(f));
      chk({tag, ".busy"}, 32'(t_busy), 32'(b));
      chk({tag, ".remaining"}, 32'(t_remaining), 32'(r));
      chk({tag, ".tick"}, 32'(sec_tick), 32'(s));
   endtask

   initial begin
      // 1: reset overrides a simultaneous start
      reset = 1'b1; t_start = 1'b1; t_length = 5'd7;
      step(); step();
      chk_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0; t_start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk_all("idle", 0, 0, 0, 0, 0);
      end

      // 2/3: length 3, edge 0 is the start edge; t_length changes afterwards are ignored
      t_start = 1'b1; t_length = 5'd3;
      step();
      t_start = 1'b0; t_length = 5'd9;
      chk_all("run3.e0", 0, 0, 1, 3, 0);
      for (int c = 1; c <= 12; c++) begin
         step();
         chk_all($sformatf("run3.e%0d", c), c == 12,
                 (c >= 4) && (c < 12) && ((c % 4) < 2), c < 12,
                 5'(3 - c / 4), (c % 4) == 0);
      end
      for (int c = 0; c < 10; c++) begin
         step();
         chk_all("done_hold", 1, 0, 0, 0, 0);
      end

      // 4: restart mid-run
      t_start = 1'b1; t_length = 5'd5;
      step();
      t_start = 1'b0;
      chk("rst5.rem", 32'(t_remaining), 5);
      chk("rst5.flick", 32'(t_flicker), 0);
      for (int c = 1; c <= 5; c++) step();
      chk("rst5.e5rem", 32'(t_remaining), 4);
      t_start = 1'b1; t_length = 5'd2;
      step();
      t_start = 1'b0;
      chk("restart.rem", 32'(t_remaining), 2);
      chk("restart.busy", 32'(t_busy), 1);
      chk("restart.flick", 32'(t_flicker), 1);
      for (int c = 7; c <= 13; c++) begin
         step();
         chk($sformatf("restart.nodone%0d", c), 32'(t_done), 0);
      end
      step();
      chk("restart.done14", 32'(t_done), 1);
      chk("restart.tick14", 32'(sec_tick), 1);
      for (int c = 15; c <= 21; c++) step();
      chk_all("restart.e21", 1, 0, 0, 0, 0);

      // 5: zero length goes straight to DONE; start from DONE clears t_done
      t_start = 1'b1; t_length = 5'd0;
      step();
      t_start = 1'b0;
      chk_all("zero", 1, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("zero.nobusy", 32'(t_busy), 0);
      end
      t_start = 1'b1; t_length = 5'd1;
      step();
      t_start = 1'b0;
      chk_all("len1.e0", 0, 1, 1, 1, 0);
      for (int c = 1; c <= 3; c++) begin
         step();
         chk($sformatf("len1.nodone%0d", c), 32'(t_done), 0);
      end
      step();
      chk_all("len1.e4", 1, 0, 0, 0, 1);

      // 6: start collides with the final wrap, then reset mid-run
      t_start = 1'b1; t_length = 5'd1;
      step();
      t_start = 1'b0;
      step(); step(); step();
      t_start = 1'b1; t_length = 5'd2;
      step();
      t_start = 1'b0;
      chk("coll.done", 32'(t_done), 0);
      chk("coll.rem", 32'(t_remaining), 2);
      chk("coll.busy", 32'(t_busy), 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_all("midreset", 0, 0, 0, 0, 0);
      for (int c = 0; c < 12; c++) begin
         step();
         chk_all("postreset", 0, 0, 0, 0, 0);
      end

      // max length loads without truncation
      t_start = 1'b1; t_length = 5'd31;
      step();
      t_start = 1'b0;
      chk("max.rem", 32'(t_remaining), 31);
      for (int c = 1; c <= 4; c++) step();
      chk("max.rem1s", 32'(t_remaining), 30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
